// File: rtl/buzzer_lockin.sv
// buzzer_lockin: sync/debounce four buttons, lock in the first press after arm; optional false-start flags via FALSE_START_EN
module buzzer_lockin #(
  parameter int N_PLAYERS = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PLAYERS-1:0] btn_raw,
  input  logic                 arm,
  input  logic                 clear,
  output logic                 armed,
  output logic                 winner_valid,
  output logic [N_PLAYERS-1:0] winner_onehot,
  output logic [1:0]           winner_idx,
  output logic                 tie,
  output logic [N_PLAYERS-1:0] foul
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;
  state_t state;
  logic [N_PLAYERS-1:0] s1, s2, lvl, lvl_d, press, elig, low;
  logic [CW-1:0] cnt [N_PLAYERS];
  logic [1:0] low_idx;
  logic multi;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      for (int i = 0; i < N_PLAYERS; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      lvl_d <= lvl;
      for (int i = 0; i < N_PLAYERS; i++)
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
          cnt[i] <= '0;
          lvl[i] <= ~lvl[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  assign press = lvl & ~lvl_d;
`ifdef FALSE_START_EN
  assign elig = press & ~foul;
  // foul survives the whole round and is dropped only when clear returns to IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) foul <= '0;
    else if (state == IDLE) foul <= foul | press;
    else if (clear && (state == LOCKED || (state == ARMED && elig == '0))) foul <= '0;
`else
  assign elig = press;
  assign foul = '0;
`endif
  assign low = elig & (~elig + N_PLAYERS'(1));
  assign low_idx = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
  assign multi = (elig & (elig - N_PLAYERS'(1))) != '0;
  assign armed = state == ARMED;
  assign winner_valid = state == LOCKED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      winner_onehot <= '0;
      winner_idx <= '0;
      tie <= 1'b0;
    end else
      case (state)
        IDLE: state <= (arm && !clear) ? ARMED : IDLE;
        ARMED:
          if (elig != '0) begin
            state <= LOCKED;
            winner_onehot <= low;
            winner_idx <= low_idx;
            tie <= multi;
          end else if (clear) state <= IDLE;
        LOCKED:
          if (clear) begin
            state <= IDLE;
            winner_onehot <= '0;
            winner_idx <= '0;
            tie <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_buzzer_lockin.sv
// tb_buzzer_lockin: window-based behavioural model plus directed scenarios for buzzer_lockin
module tb_buzzer_lockin;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, clear = 1'b0;
  logic [3:0] btn_raw = '0;
  logic armed, winner_valid, tie;
  logic [3:0] winner_onehot, foul;
  logic [1:0] winner_idx;
  int total = 0, bad = 0;
  buzzer_lockin #(.N_PLAYERS(4), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .arm(arm), .clear(clear),
    .armed(armed), .winner_valid(winner_valid), .winner_onehot(winner_onehot),
    .winner_idx(winner_idx), .tie(tie), .foul(foul)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  // Model: a level flips once D+1 consecutive raw samples (seen two edges late) all differ from it
  logic [3:0] hist [0:8191];
  int n;
  int m_st;
  logic [3:0] m_lvl, m_press, m_on, m_foul, elig, nlvl;
  int m_idx;
  logic m_tie;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_lvl = '0; m_press = '0; m_st = 0;
      m_on = '0; m_idx = 0; m_tie = 1'b0; m_foul = '0;
    end else begin
      hist[n] = btn_raw;
      elig = m_press & ~m_foul;
      if (m_st == 0) begin
`ifdef FALSE_START_EN
        m_foul = m_foul | m_press;
`endif
        if (arm && !clear) m_st = 1;
      end else if (m_st == 1) begin
        if (elig != 0) begin
          m_st = 2;
          m_tie = $countones(elig) > 1;
          m_on = '0;
          for (int b = 3; b >= 0; b--) if (elig[b]) begin m_on = 4'b0001 << b; m_idx = b; end
        end else if (clear) begin
          m_st = 0; m_foul = '0;
        end
      end else if (clear) begin
        m_st = 0; m_on = '0; m_idx = 0; m_tie = 1'b0; m_foul = '0;
      end
      nlvl = m_lvl;
      for (int b = 0; b < 4; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = n - 2 - D; j <= n - 2; j++)
          if (((j < 0) ? 1'b0 : hist[j][b]) == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) nlvl[b] = ~m_lvl[b];
      end
      m_press = nlvl & ~m_lvl;
      m_lvl = nlvl;
      n++;
    end
  end
  always @(negedge clk) begin
    chk("armed", armed, m_st == 1);
    chk("winner_valid", winner_valid, m_st == 2);
    chk("winner_onehot", winner_onehot, m_on);
    chk("winner_idx", winner_idx, m_idx);
    chk("tie", tie, m_tie);
    chk("foul", foul, m_foul);
  end
  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #2; end
  endtask
  task automatic pulse_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
  endtask
  initial begin
    int lat;
    tick(2);
    chk("reset_outputs", {armed, winner_valid, winner_onehot, winner_idx, tie, foul}, 0);
    rst_n = 1'b1;
    tick(2);
    clear = 1'b1; arm = 1'b1; tick(1); clear = 1'b0; arm = 1'b0;
    chk("arm_clear_idle", armed, 0);
    pulse_arm();
    chk("armed_after_arm", armed, 1);
    btn_raw = 4'b0100;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (winner_valid) begin lat = i; break; end
    end
    chk("lock_latency", lat, 3 + D);
    chk("p2_onehot", winner_onehot, 4'b0100);
    chk("p2_idx", winner_idx, 2);
    chk("p2_tie", tie, 0);
    chk("p2_armed", armed, 0);
    tick(4);
    btn_raw = 4'b0110; tick(10); btn_raw = 4'b0100; tick(10);
    chk("locked_hold", winner_onehot, 4'b0100);
    pulse_clear();
    chk("clear_onehot", winner_onehot, 0);
    chk("clear_valid", winner_valid, 0);
    pulse_arm();
    tick(12);
    chk("held_no_win", winner_valid, 0);
    btn_raw = 4'b0000; tick(10);
    btn_raw = 4'b0100; tick(10);
    chk("repress_win", winner_onehot, 4'b0100);
    btn_raw = 4'b0000; tick(10);
    pulse_clear();
    pulse_arm();
    btn_raw = 4'b1001; tick(10);
    chk("tie_onehot", winner_onehot, 4'b0001);
    chk("tie_idx", winner_idx, 0);
    chk("tie_flag", tie, 1);
    btn_raw = 4'b0000; tick(10);
    pulse_clear();
    pulse_arm();
    btn_raw = 4'b0010; tick(3); btn_raw = 4'b0000; tick(10);
    chk("glitch_armed", armed, 1);
    chk("glitch_onehot", winner_onehot, 0);
    pulse_clear();
    chk("armed_clear", armed, 0);
    pulse_arm();
    btn_raw = 4'b1000; tick(10);
    chk("p3_onehot", winner_onehot, 4'b1000);
    chk("p3_idx", winner_idx, 3);
    @(posedge clk); #3;
    rst_n = 1'b0; btn_raw = 4'b0000;
    #1;
    chk("async_rst_onehot", winner_onehot, 0);
    chk("async_rst_valid", winner_valid, 0);
    tick(2);
    rst_n = 1'b1;
    btn_raw = 4'b0100; tick(10);
    chk("no_arm_no_win", winner_valid, 0);
    btn_raw = 4'b0000; tick(10);
    pulse_arm();
    btn_raw = 4'b1000; tick(10);
    chk("post_rst_win", winner_onehot, 4'b1000);
    btn_raw = 4'b0000; tick(10);
    pulse_clear();
`ifdef FALSE_START_EN
    btn_raw = 4'b1000; tick(10);
    chk("foul_set", foul, 4'b1000);
    btn_raw = 4'b0000; tick(10);
    pulse_arm();
    btn_raw = 4'b1000; tick(10);
    chk("foul_no_lock", winner_valid, 0);
    btn_raw = 4'b0010; tick(10);
    chk("foul_p1_win", winner_onehot, 4'b0010);
    btn_raw = 4'b0000; tick(10);
    pulse_clear();
    chk("foul_cleared", foul, 0);
`else
    chk("foul_tied_off", foul, 0);
`endif
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
